// File: rtl/i_fetch_pkg.sv
// i_fetch_pkg: word width, NOP encoding and opcode constants shared by fetch and decode.
package i_fetch_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;
  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/i_fetch_mem.sv
// i_mem: instruction memory, one synchronous write port and one combinational read port;
// byte addresses outside DEPTH words are ignored on write and read back as NOP.
module i_mem
  import i_fetch_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [WORD_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic w_ok, r_ok, unused_bits;
  assign w_ok = waddr_i[WORD_W-1:AW+2] == '0;
  assign r_ok = raddr_i[WORD_W-1:AW+2] == '0;
  assign unused_bits = ^{waddr_i[1:0], raddr_i[1:0]};
  always_ff @(posedge clk) begin
    if (we_i && w_ok) mem_q[waddr_i[AW+1:2]] <= wdata_i;
  end
  assign rdata_o = r_ok ? mem_q[raddr_i[AW+1:2]] : NOP_INSTR;
endmodule

// File: rtl/i_fetch.sv
// i_fetch: MIPS IF stage owning the PC, reading instruction memory and loading IF/ID;
// a taken branch beats flush, which beats stall.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter int                IMEM_DEPTH = 128,
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCSrc,
  input  logic [WORD_W-1:0] EX_MEM_NPC,
  input  logic              stall,
  input  logic              flush,
  input  logic              imem_we,
  input  logic [WORD_W-1:0] imem_waddr,
  input  logic [WORD_W-1:0] imem_wdata,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] IF_ID_instr,
  output logic [WORD_W-1:0] IF_ID_NPC,
  output logic              IF_ID_valid
);
  logic [WORD_W-1:0] pc_q, pc_d, instr_q, instr_d, npc_q, npc_d, fetch_word, pc_plus4;
  logic valid_q, valid_d, bubble, hold;
  i_mem #(.DEPTH(IMEM_DEPTH)) u_mem (
    .clk    (clk),
    .we_i   (imem_we),
    .waddr_i(imem_waddr),
    .wdata_i(imem_wdata),
    .raddr_i(pc_q),
    .rdata_o(fetch_word)
  );
  assign pc_plus4 = pc_q + 32'd4;
  assign bubble   = PCSrc || flush;
  assign hold     = stall && !bubble;
  always_comb begin
    pc_d    = PCSrc ? word_align(EX_MEM_NPC) : hold ? pc_q : pc_plus4;
    instr_d = bubble ? NOP_INSTR : hold ? instr_q : fetch_word;
    npc_d   = bubble ? '0 : hold ? npc_q : pc_plus4;
    valid_d = bubble ? 1'b0 : hold ? valid_q : 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end
  assign PC          = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_NPC   = npc_q;
  assign IF_ID_valid = valid_q;
endmodule

// File: tb/tb_i_fetch.sv
// tb_i_fetch: directed vector table for the fetch/stall/branch/flush corners, then
// randomized traffic checked against a word-array reference model of the IF stage.
module tb_i_fetch;
  localparam int DEPTH = 128;
  localparam logic [31:0] LIM = 32'(4 * DEPTH);
  logic clk = 1'b0, rst = 1'b1, PCSrc = 1'b0, stall = 1'b0, flush = 1'b0, imem_we = 1'b0;
  logic [31:0] EX_MEM_NPC = '0, imem_waddr = '0, imem_wdata = '0;
  logic [31:0] PC, IF_ID_instr, IF_ID_NPC;
  logic IF_ID_valid;
  int n_tests = 0, n_fail = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc = '0, m_instr = '0, m_npc = '0;
  logic m_valid = 1'b0;

  i_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .EX_MEM_NPC(EX_MEM_NPC), .stall(stall),
    .flush(flush), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .PC(PC), .IF_ID_instr(IF_ID_instr), .IF_ID_NPC(IF_ID_NPC), .IF_ID_valid(IF_ID_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pcsrc; logic [31:0] tgt; logic stall; logic flush;
    logic [31:0] pc; logic [31:0] instr; logic [31:0] npc; logic valid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] npc, input logic v);
    chk({tag, ".PC"}, PC, pc);
    chk({tag, ".instr"}, IF_ID_instr, ins);
    chk({tag, ".NPC"}, IF_ID_NPC, npc);
    chk({tag, ".valid"}, {31'b0, IF_ID_valid}, {31'b0, v});
  endtask

  // One clock edge: the reference model advances from the inputs held across the edge.
  task automatic tick();
    logic [31:0] f, p4;
    f  = (m_pc < LIM) ? m_mem[m_pc / 4] : 32'h0;
    p4 = m_pc + 32'd4;
    if (imem_we && imem_waddr < LIM) m_mem[imem_waddr / 4] = imem_wdata;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_npc = 0; m_valid = 0;
    end else if (PCSrc) begin
      m_pc = EX_MEM_NPC - (EX_MEM_NPC % 4); m_instr = 0; m_npc = 0; m_valid = 0;
    end else if (flush) begin
      m_pc = p4; m_instr = 0; m_npc = 0; m_valid = 0;
    end else if (!stall) begin
      m_pc = p4; m_instr = f; m_npc = p4; m_valid = 1;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];
  logic [31:0] prog [4];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    prog[0] = 32'h8C123456; prog[1] = 32'hAC654321; prog[2] = 32'h10654321; prog[3] = 32'h002300AA;
    vt.push_back('{0, 0, 0, 0, 32'h4,  32'h8C123456, 32'h4,  1});
    vt.push_back('{0, 0, 0, 0, 32'h8,  32'hAC654321, 32'h8,  1});
    vt.push_back('{0, 0, 1, 0, 32'h8,  32'hAC654321, 32'h8,  1});
    vt.push_back('{0, 0, 1, 0, 32'h8,  32'hAC654321, 32'h8,  1});
    vt.push_back('{0, 0, 0, 0, 32'hC,  32'h10654321, 32'hC,  1});
    vt.push_back('{1, 32'h6, 1, 0, 32'h4, 32'h0, 32'h0, 0});
    vt.push_back('{0, 0, 0, 0, 32'h8,  32'hAC654321, 32'h8,  1});
    vt.push_back('{1, 32'h4, 0, 0, 32'h4, 32'h0, 32'h0, 0});
    vt.push_back('{0, 0, 0, 1, 32'h8,  32'h0,        32'h0,  0});
    vt.push_back('{0, 0, 0, 0, 32'hC,  32'h10654321, 32'hC,  1});
    vt.push_back('{0, 0, 0, 0, 32'h10, 32'h002300AA, 32'h10, 1});
    vt.push_back('{0, 0, 1, 1, 32'h14, 32'h0,        32'h0,  0});
    vt.push_back('{1, 32'h200, 0, 0, 32'h200, 32'h0, 32'h0, 0});
    vt.push_back('{0, 0, 0, 0, 32'h204, 32'h0, 32'h204, 1});
    vt.push_back('{1, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 0});
    vt.push_back('{0, 0, 0, 0, 32'h0,  32'h0,        32'h0,  1});
    vt.push_back('{0, 0, 0, 0, 32'h4,  32'h8C123456, 32'h4,  1});

    // Program load while held in reset
    for (int i = 0; i < 4; i++) begin
      imem_we = 1; imem_waddr = 32'(4 * i); imem_wdata = prog[i];
      tick();
    end
    imem_we = 0;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 0;

    foreach (vt[i]) begin
      PCSrc = vt[i].pcsrc; EX_MEM_NPC = vt[i].tgt; stall = vt[i].stall; flush = vt[i].flush;
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].instr, vt[i].npc, vt[i].valid);
    end
    PCSrc = 0; stall = 0; flush = 0;

    // Write to the word being fetched on the same edge: old data captured, new on refetch
    PCSrc = 1; EX_MEM_NPC = 32'h8; tick(); PCSrc = 0;
    imem_we = 1; imem_waddr = 32'h8; imem_wdata = 32'hDEADBEEF;
    tick();
    imem_we = 0;
    chk("wr_same_edge.instr", IF_ID_instr, 32'h10654321);
    PCSrc = 1; EX_MEM_NPC = 32'h8; tick(); PCSrc = 0;
    tick();
    chk("wr_refetch.instr", IF_ID_instr, 32'hDEADBEEF);
    chk("wr_refetch.NPC", IF_ID_NPC, 32'hC);

    // Asynchronous reset mid-run takes effect without a clock edge
    @(negedge clk);
    rst = 1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    rst = 0;
    tick();
    chk("restart.instr", IF_ID_instr, 32'h8C123456);
    chk("restart.PC", PC, 32'h4);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      PCSrc = ($urandom % 8) == 0;
      stall = ($urandom % 3) == 0;
      flush = ($urandom % 7) == 0;
      EX_MEM_NPC = (($urandom % 5) == 0) ? $urandom : ($urandom % (LIM + 64));
      imem_we = ($urandom % 3) == 0;
      imem_waddr = (($urandom % 6) == 0) ? $urandom : ($urandom % (LIM + 32));
      imem_wdata = $urandom;
      tick();
      chk_all($sformatf("rnd%0d", c), m_pc, m_instr, m_npc, m_valid);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
